uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
// Transmit-side scheduler that sits between the host bus and the UART serializer.
// Holds a DEPTH-entry character FIFO plus a single-entry priority control-character slot (XON/XOFF).
// Drives the serializer's thre/din and consumes its pop/sreg_empty handshake.
// Applies flow-control pause to FIFO traffic only; control characters always bypass the pause.
// PARAMETERS
// DEPTH   16  FIFO entries; power of 2, >= 2
// AW      4   $clog2(DEPTH); pointer width
// PORTS
// clk         in   1     system clock
// rst         in   1     asynchronous, active-high reset
// wr_en       in   1     host write strobe, one character per cycle
// wr_data     in   8     host character
// full        out  1     FIFO holds DEPTH entries
// fifo_count  out  AW+1  FIFO occupancy, 0..DEPTH
// overrun     out  1     sticky: a write was dropped while full
// ovr_clr     in   1     clears overrun; a drop in the same cycle wins
// ctl_req     in   1     load ctl_data into the priority slot
// ctl_data    in   8     control character (e.g. 8'h11 / 8'h13)
// ctl_busy    out  1     priority slot occupied or its character in flight
// ctl_ack     out  1     1-cycle pulse: control character handed to serializer
// tx_pause    in   1     flow-control hold; blocks arming from the FIFO only
// pop         in   1     serializer read strobe; stays high for many clk cycles
// sreg_empty  in   1     serializer shift register drained
// thre        out  1     0 = character armed on din for the serializer
// din         out  8     armed character, registered
// temt        out  1     transmitter fully empty
// BEHAVIOUR
// - Reset: state=IDLE; pointers, count, overrun, ctl_busy, ctl_ack, din=0; thre=1, pop_q=0.
// - Edge detect: pop_q <= pop; pop_rise = pop & ~pop_q. Only pop_rise is acted on.
// - FIFO: push on wr_en & (~full | deq_this_cycle); a push to a full FIFO in any other case sets overrun.
// - Pointers wrap modulo DEPTH. Simultaneous push and dequeue leaves fifo_count unchanged.
// - Priority slot: ctl_req with ~ctl_busy loads the slot and sets ctl_busy.
// - ctl_req while ctl_busy is ignored; no error flag is raised.
// - FSM IDLE: if the slot is pending -> ARMED, din<=slot, src=CTL.
// - FSM IDLE: else if ~fifo_empty & ~tx_pause -> ARMED, din<=head, dequeue (this is deq_this_cycle), src=FIFO.
// - FSM IDLE: otherwise stay in IDLE. thre=1.
// - FSM ARMED: thre=0; din and src are frozen.
// - FSM ARMED: on pop_rise -> BUSY. If src=CTL, pulse ctl_ack and clear ctl_busy in that same cycle.
// - FSM ARMED: tx_pause asserted while ARMED does not disarm.
// - FSM BUSY: thre=1; wait for pop==0, then -> IDLE. A new character can arm 1 cycle later.
// - Latency: write at edge N into an empty IDLE block -> state ARMED and thre=0 after edge N+1.
// - Arbitration: a pending slot always beats a non-empty FIFO at the IDLE decision.
// - A ctl_req arriving while ARMED on FIFO data waits for the next IDLE decision.
// - temt = (state==IDLE) & fifo_empty & ~ctl_busy & sreg_empty.
// - Reset mid-character: all state is discarded and thre returns to 1 immediately.
// - Reset mid-character: a partially sent frame is the serializer's concern.
// TESTING
// 1. Reset, write 8'hA5, hold pop=0 -> thre=0 and din=8'hA5 at N+1, fifo_count back to 0;
//    pop high 20 cycles -> BUSY, then IDLE after pop falls.
// 2. Write 17 chars with no pop -> first char armed, 16 in FIFO (full=1), 18th write sets overrun;
//    ovr_clr clears it.
// 3. FIFO holds 3 chars, tx_pause=1 -> thre stays 1; ctl_req 8'h13 -> armed anyway;
//    pop_rise -> ctl_ack pulse, ctl_busy=0.
// 4. Char 8'h41 armed, then ctl_req 8'h11 -> din stays 8'h41 until pop_rise;
//    next arm is 8'h11 ahead of FIFO char 8'h42.
// 5. Full FIFO, IDLE arming dequeue and wr_en in the same cycle -> write accepted,
//    fifo_count stays DEPTH, no overrun.
// 6. Assert rst while ARMED with 4 chars queued -> thre=1, fifo_count=0, ctl_busy=0, temt follows sreg_empty.

Source files
------------

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: DEPTH-entry character FIFO plus a one-deep priority control slot,
// arming characters onto din/thre for the serializer and tracking its pop handshake.
module uart_tx_sched #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic [AW:0]   fifo_count,
    output logic          overrun,
    input  logic          ovr_clr,
    input  logic          ctl_req,
    input  logic [7:0]    ctl_data,
    output logic          ctl_busy,
    output logic          ctl_ack,
    input  logic          tx_pause,
    input  logic          pop,
    input  logic          sreg_empty,
    output logic          thre,
    output logic [7:0]    din,
    output logic          temt
);

    typedef enum logic [1:0] {IDLE, ARMED, BUSY} state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          ctl_busy_q, ctl_busy_d;
    logic          slot_pend_q, slot_pend_d;
    logic [7:0]    slot_q, slot_d;
    logic          ctl_ack_q, ctl_ack_d;
    logic          src_ctl_q, src_ctl_d;
    logic [7:0]    din_q, din_d;
    logic          pop_q;
    logic [7:0]    mem_q [DEPTH];

    logic pop_rise, fifo_empty, deq, push;

    assign fifo_empty = (count_q == '0);
    assign full       = (count_q == FULL_CNT);
    assign pop_rise   = pop & ~pop_q;
    assign push       = wr_en & (~full | deq);

    always_comb begin
        state_d     = state_q;
        src_ctl_d   = src_ctl_q;
        din_d       = din_q;
        slot_d      = slot_q;
        slot_pend_d = slot_pend_q;
        ctl_busy_d  = ctl_busy_q;
        ctl_ack_d   = 1'b0;
        deq         = 1'b0;

        case (state_q)
            IDLE: begin
                // A pending control character always wins over queued data.
                if (slot_pend_q) begin
                    state_d     = ARMED;
                    din_d       = slot_q;
                    src_ctl_d   = 1'b1;
                    slot_pend_d = 1'b0;
                end else if (!fifo_empty && !tx_pause) begin
                    state_d   = ARMED;
                    din_d     = mem_q[rd_ptr_q];
                    src_ctl_d = 1'b0;
                    deq       = 1'b1;
                end
            end
            ARMED: begin
                if (pop_rise) begin
                    state_d = BUSY;
                    if (src_ctl_q) begin
                        ctl_ack_d  = 1'b1;
                        ctl_busy_d = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (!pop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Gated on the registered busy flag, so a release and a new request never collide.
        if (ctl_req && !ctl_busy_q) begin
            slot_d      = ctl_data;
            slot_pend_d = 1'b1;
            ctl_busy_d  = 1'b1;
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = deq  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, deq};

        overrun_d = overrun_q;
        if (wr_en && full && !deq) overrun_d = 1'b1;
        else if (ovr_clr)          overrun_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            ctl_busy_q  <= 1'b0;
            slot_pend_q <= 1'b0;
            slot_q      <= 8'h00;
            ctl_ack_q   <= 1'b0;
            src_ctl_q   <= 1'b0;
            din_q       <= 8'h00;
            pop_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            ctl_busy_q  <= ctl_busy_d;
            slot_pend_q <= slot_pend_d;
            slot_q      <= slot_d;
            ctl_ack_q   <= ctl_ack_d;
            src_ctl_q   <= src_ctl_d;
            din_q       <= din_d;
            pop_q       <= pop;
        end
    end

    // Storage only; occupancy is tracked by the reset pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign fifo_count = count_q;
    assign overrun    = overrun_q;
    assign ctl_busy   = ctl_busy_q;
    assign ctl_ack    = ctl_ack_q;
    assign din        = din_q;
    assign thre       = (state_q != ARMED);
    assign temt       = (state_q == IDLE) & fifo_empty & ~ctl_busy_q & sreg_empty;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus randomized traffic, all checked
// against a queue-based transaction model of the scheduler.
module tb_uart_tx_sched;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, ovr_clr, ctl_req, tx_pause, pop, sreg_empty;
    logic [7:0]    wr_data, ctl_data;
    logic          full, overrun, ctl_busy, ctl_ack, thre, temt;
    logic [AW:0]   fifo_count;
    logic [7:0]    din;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_sched #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .fifo_count(fifo_count), .overrun(overrun), .ovr_clr(ovr_clr),
        .ctl_req(ctl_req), .ctl_data(ctl_data), .ctl_busy(ctl_busy), .ctl_ack(ctl_ack),
        .tx_pause(tx_pause), .pop(pop), .sreg_empty(sreg_empty), .thre(thre),
        .din(din), .temt(temt)
    );

    always #5 clk = ~clk;

    // Transaction-level model: a queue of characters plus "character on offer"
    // and "serializer still holding pop" flags.
    logic [7:0] mq[$];
    bit         m_armed, m_wait_low, m_from_ctl, m_slot_pend, m_ctl_busy, m_ack, m_ovr, m_pop_prev;
    logic [7:0] m_din, m_slot;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_armed = 0; m_wait_low = 0; m_from_ctl = 0; m_slot_pend = 0;
        m_ctl_busy = 0; m_ack = 0; m_ovr = 0; m_pop_prev = 0;
        m_din = 8'h00; m_slot = 8'h00;
    endfunction

    function automatic void model_step();
        bit was_full  = (mq.size() == DEPTH);
        bit busy_old  = m_ctl_busy;
        bit rise      = pop && !m_pop_prev;
        bit took      = 0;
        m_ack = 0;
        if (!m_armed && !m_wait_low) begin
            if (m_slot_pend) begin
                m_armed = 1; m_din = m_slot; m_from_ctl = 1; m_slot_pend = 0;
            end else if (mq.size() > 0 && !tx_pause) begin
                m_armed = 1; m_din = mq.pop_front(); m_from_ctl = 0; took = 1;
            end
        end else if (m_armed) begin
            if (rise) begin
                m_armed = 0; m_wait_low = 1;
                if (m_from_ctl) begin m_ack = 1; m_ctl_busy = 0; end
            end
        end else if (!pop) begin
            m_wait_low = 0;
        end
        if (ctl_req && !busy_old) begin
            m_slot = ctl_data; m_slot_pend = 1; m_ctl_busy = 1;
        end
        if (wr_en && (!was_full || took)) mq.push_back(wr_data);
        if (wr_en && was_full && !took) m_ovr = 1;
        else if (ovr_clr)               m_ovr = 0;
        m_pop_prev = pop;
    endfunction

    task automatic check_all();
        chk("thre",       thre,       !m_armed);
        if (m_armed) chk("din", din, m_din);
        chk("fifo_count", fifo_count, mq.size());
        chk("full",       full,       mq.size() == DEPTH);
        chk("overrun",    overrun,    m_ovr);
        chk("ctl_busy",   ctl_busy,   m_ctl_busy);
        chk("ctl_ack",    ctl_ack,    m_ack);
        chk("temt",       temt,       !m_armed && !m_wait_low && mq.size() == 0 && !m_ctl_busy && sreg_empty);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drain();
        int guard = 0;
        while ((m_armed || m_wait_low || m_slot_pend || mq.size() > 0) && guard < 100) begin
            pop = 1'b1; step();
            pop = 1'b0; step();
            step();
            guard++;
        end
        chk("drain_done", guard < 100, 1);
    endtask

    initial begin
        int pop_cnt;
        rst = 1'b1; wr_en = 0; wr_data = 0; ovr_clr = 0; ctl_req = 0; ctl_data = 0;
        tx_pause = 0; pop = 0; sreg_empty = 1;
        model_reset();
        step(); step();
        chk("rst_thre", thre, 1); chk("rst_din", din, 8'h00);
        chk("rst_count", fifo_count, 0); chk("rst_temt", temt, 1);
        rst = 1'b0;

        // Single character: armed one edge after the write, then pop handshake.
        wr_en = 1; wr_data = 8'hA5; step();
        wr_en = 0; step();
        chk("t1_thre", thre, 0); chk("t1_din", din, 8'hA5); chk("t1_count", fifo_count, 0);
        pop = 1; repeat (20) step();
        chk("t1_busy_thre", thre, 1); chk("t1_busy_temt", temt, 0);
        pop = 0; step();
        chk("t1_idle_temt", temt, 1);

        // Fill past capacity, overrun, clear, then simultaneous dequeue and write while full.
        for (int i = 0; i < 18; i++) begin
            wr_en = 1; wr_data = 8'h30 + 8'(i); step();
        end
        wr_en = 0;
        chk("t2_full", full, 1); chk("t2_count", fifo_count, 16);
        chk("t2_ovr", overrun, 1); chk("t2_din", din, 8'h30);
        ovr_clr = 1; step(); ovr_clr = 0;
        chk("t2_ovr_clr", overrun, 0);
        pop = 1; step(); pop = 0; step();
        chk("t5_pre_full", full, 1);
        wr_en = 1; wr_data = 8'h77; step(); wr_en = 0;
        chk("t5_count", fifo_count, 16); chk("t5_ovr", overrun, 0); chk("t5_din", din, 8'h31);
        drain();

        // Pause holds FIFO data but not a control character.
        tx_pause = 1;
        for (int i = 0; i < 3; i++) begin wr_en = 1; wr_data = 8'h60 + 8'(i); step(); end
        wr_en = 0; step();
        chk("t3_paused_thre", thre, 1); chk("t3_count", fifo_count, 3);
        ctl_req = 1; ctl_data = 8'h13; step(); ctl_req = 0; step();
        chk("t3_ctl_thre", thre, 0); chk("t3_ctl_din", din, 8'h13); chk("t3_ctl_busy", ctl_busy, 1);
        pop = 1; step();
        chk("t3_ack", ctl_ack, 1); chk("t3_busy_clr", ctl_busy, 0);
        pop = 0; step();
        chk("t3_ack_pulse", ctl_ack, 0);
        tx_pause = 0; drain();

        // Control request during FIFO character waits, then beats the queued FIFO character.
        wr_en = 1; wr_data = 8'h41; step();
        wr_en = 0; step();
        wr_en = 1; wr_data = 8'h42; ctl_req = 1; ctl_data = 8'h11; step();
        wr_en = 0; ctl_req = 0; step();
        chk("t4_hold_din", din, 8'h41); chk("t4_hold_thre", thre, 0);
        pop = 1; step(); pop = 0; step(); step();
        chk("t4_ctl_first", din, 8'h11);
        pop = 1; step(); chk("t4_ack", ctl_ack, 1);
        pop = 0; step(); step();
        chk("t4_fifo_next", din, 8'h42);
        drain();

        // Asynchronous reset while armed with data queued and the slot busy.
        for (int i = 0; i < 5; i++) begin wr_en = 1; wr_data = 8'h50 + 8'(i); step(); end
        wr_en = 0; ctl_req = 1; ctl_data = 8'h13; step(); ctl_req = 0;
        chk("t6_pre_count", fifo_count, 4); chk("t6_pre_busy", ctl_busy, 1);
        rst = 1; #1;
        chk("t6_thre", thre, 1); chk("t6_count", fifo_count, 0); chk("t6_ctl_busy", ctl_busy, 0);
        sreg_empty = 0; #1; chk("t6_temt_lo", temt, 0);
        sreg_empty = 1; #1; chk("t6_temt_hi", temt, 1);
        model_reset();
        step(); rst = 0; step();

        // Randomized traffic.
        pop_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            wr_en      = ($urandom_range(99) < 40);
            wr_data    = 8'($urandom);
            ctl_req    = ($urandom_range(99) < 5);
            ctl_data   = ($urandom_range(1) == 1) ? 8'h11 : 8'h13;
            ovr_clr    = ($urandom_range(99) < 3);
            sreg_empty = ($urandom_range(99) < 70);
            if ($urandom_range(99) < 4) tx_pause = ~tx_pause;
            if (pop_cnt > 0) begin
                pop = 1; pop_cnt--;
            end else if (!pop && $urandom_range(99) < 20) begin
                pop = 1; pop_cnt = $urandom_range(7);
            end else begin
                pop = 0;
            end
            step();
        end
        wr_en = 0; ctl_req = 0; ovr_clr = 0; tx_pause = 0; pop = 0; sreg_empty = 1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
